vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Downstream consumer of frame_buffer: generates 640x480@60 VGA timing from clk (25.175 MHz),
//  walks frame_buffer read_addr in raster order, converts the 1-bit read_data to 4:4:4 RGB and
//  drives hsync/vsync. Also issues the once-per-frame swap pulse that frame_buffer and
//  graphics_fsm use to flip draw/display buffers.
// PARAMETERS
//  HOR_ACTIVE_PIXELS  640  visible pixels per line
//  HOR_FRONT_PORCH    16   pixels after active, before hsync
//  HOR_SYNC_PULSE     96   hsync pulse width (pixels)
//  HOR_BACK_PORCH     48   pixels after hsync, before next active
//  VER_ACTIVE_PIXELS  480  visible lines per frame
//  VER_FRONT_PORCH    10   lines after active, before vsync
//  VER_SYNC_PULSE     2    vsync pulse width (lines)
//  VER_BACK_PORCH     33   lines after vsync, before next active
//  SYNC_ACTIVE_LEVEL  0    sync pulse level (0 = negative polarity)
//  Derived: H_TOTAL=800, V_TOTAL=525, ADDR_WIDTH=$clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS)
// PORTS
//  clk        in   1           pixel clock
//  rst        in   1           asynchronous reset, active-high
//  read_addr  out  ADDR_WIDTH  frame_buffer read address (combinational from stage-0 regs)
//  read_data  in   1           frame_buffer pixel; valid 1 cycle after read_addr (registered RAM)
//  swap       out  1           1-cycle pulse, start of vertical blank
//  vga_hsync  out  1           horizontal sync
//  vga_vsync  out  1           vertical sync
//  vga_red    out  4           {4{pixel}}; 0 outside active
//  vga_green  out  4           as vga_red
//  vga_blue   out  4           as vga_red
// BEHAVIOUR
//  Stage 0 (counters): h_cnt 0..H_TOTAL-1, wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1
//   wraps to 0. active0 = (h_cnt<HOR_ACTIVE_PIXELS)&&(v_cnt<VER_ACTIVE_PIXELS).
//  Address counter (no multiplier): addr increments by 1 on every active0 cycle; forced to 0 on
//   every cycle with v_cnt>=VER_ACTIVE_PIXELS. Holds during horizontal blank, so it already points
//   at the next line's first pixel. read_addr = addr; never exceeds PIXELS_COUNT-1.
//  hsync0 active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751);
//   vsync0 active when 490 <= v_cnt < 492. Active level = SYNC_ACTIVE_LEVEL.
//  Stage 1: register active0, hsync0, vsync0 (aligns with read_data arriving from RAM).
//  Stage 2 (output regs): colour = {4{read_data & active1}} to all three channels; syncs <= stage 1.
//   Total latency counter->pins = 2 cycles, identical for colour and syncs (no skew).
//  swap: registered; high for exactly one cycle, the cycle after stage 0 reaches h_cnt==0,
//   v_cnt==VER_ACTIVE_PIXELS; one pulse per frame, never during active lines.
//  Reset (async assert, sync release at clk edge): h_cnt=v_cnt=0, addr=0, pipeline active=0,
//   syncs at inactive level (~SYNC_ACTIVE_LEVEL), colours 0, swap 0. First cycle after release is
//   pixel (0,0) of a new frame. Reset mid-frame discards the partial frame; no swap emitted for it.
//  No flow control: read_data is sampled unconditionally; block never stalls.
// STRUCTURE
//  Shared include vga_timings.vh: 640x480@60 porch/sync constants and H_TOTAL/V_TOTAL, reused by
//   testbenches and any future timing variant.
//  One natural sub-module: vga_timing (h/v counters + active/hsync/vsync/frame_start), leaving
//   vga_scanout to own address counter, pipeline alignment and swap.
// TESTING
//  Reset: hold rst 5 cycles -> hsync=vsync=1, RGB=0, swap=0, read_addr=0 throughout.
//  Line timing: after release, vga_hsync falls at cycle 658 (656+2), stays low 96 cycles, period
//   800; RGB zero in all cycles whose stage-0 h_cnt>=640.
//  Frame timing: vsync low for exactly 1600 cycles starting 490*800+2 after release, period
//   420000; swap pulses exactly once per 420000 cycles, at cycle 384001 after release.
//  Address walk: read_addr = 0..639 on line 0, holds 640 through h-blank, 307199 on last active
//   pixel, 0 during entire v-blank; model RAM with pattern pixel=addr[0]^addr[9] and check RGB
//   matches the model 2 cycles later on every active pixel.
//  Async reset mid-line (assert at v=100,h=300, between clk edges): outputs go to reset values
//   immediately without a clock edge; after release timing restarts at (0,0), no swap until 384001.

Source files
------------

// File: rtl/vga_scanout_pkg.sv
// rtl/vga_scanout_pkg.sv - 640x480@60 timing defaults and shared types for the VGA scanout
package vga_scanout_pkg;

  localparam int VGA_HOR_ACTIVE = 640;
  localparam int VGA_HOR_FRONT  = 16;
  localparam int VGA_HOR_SYNC   = 96;
  localparam int VGA_HOR_BACK   = 48;
  localparam int VGA_VER_ACTIVE = 480;
  localparam int VGA_VER_FRONT  = 10;
  localparam int VGA_VER_SYNC   = 2;
  localparam int VGA_VER_BACK   = 33;
  localparam int VGA_ADDR_WIDTH = $clog2(VGA_HOR_ACTIVE * VGA_VER_ACTIVE);

  // Pipeline-stage flags; sync fields mean "inside the pulse", not pin level.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } stage_t;

  function automatic logic in_window(input int cnt, input int lo, input int len);
    return (cnt >= lo) && (cnt < lo + len);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - frame_buffer read port and buffer-swap strobe
interface vga_scanout_if #(
  parameter int ADDR_WIDTH = vga_scanout_pkg::VGA_ADDR_WIDTH
) ();
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_data;
  logic                  swap;

  modport master (output read_addr, output swap, input read_data);
  modport slave  (input read_addr, input swap, output read_data);
endinterface

// File: rtl/vga_scanout_timing.sv
// rtl/vga_scanout_timing.sv - h/v raster counters with active, sync-window and frame-start decode
module vga_scanout_timing
  import vga_scanout_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = VGA_HOR_ACTIVE,
  parameter int HOR_FRONT_PORCH   = VGA_HOR_FRONT,
  parameter int HOR_SYNC_PULSE    = VGA_HOR_SYNC,
  parameter int HOR_BACK_PORCH    = VGA_HOR_BACK,
  parameter int VER_ACTIVE_PIXELS = VGA_VER_ACTIVE,
  parameter int VER_FRONT_PORCH   = VGA_VER_FRONT,
  parameter int VER_SYNC_PULSE    = VGA_VER_SYNC,
  parameter int VER_BACK_PORCH    = VGA_VER_BACK
) (
  input  logic   clk,
  input  logic   rst,
  output stage_t stage0,
  output logic   frame_start,
  output logic   vblank
);
  localparam int H_TOTAL = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_PULSE + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_ACTIVE_PIXELS + VER_FRONT_PORCH + VER_SYNC_PULSE + VER_BACK_PORCH;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;

  assign h_last = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last = (v_cnt == VW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + HW'(1);
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + VW'(1);
    end
  end

  always_comb begin
    stage0.active = (int'(h_cnt) < HOR_ACTIVE_PIXELS) && (int'(v_cnt) < VER_ACTIVE_PIXELS);
    stage0.hsync  = in_window(int'(h_cnt), HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH, HOR_SYNC_PULSE);
    stage0.vsync  = in_window(int'(v_cnt), VER_ACTIVE_PIXELS + VER_FRONT_PORCH, VER_SYNC_PULSE);
  end

  assign frame_start = (h_cnt == '0) && (int'(v_cnt) == VER_ACTIVE_PIXELS);
  assign vblank      = (int'(v_cnt) >= VER_ACTIVE_PIXELS);

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scanout: raster address walk, 2-stage pixel/sync alignment, swap strobe
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int HOR_ACTIVE_PIXELS = VGA_HOR_ACTIVE,
  parameter int HOR_FRONT_PORCH   = VGA_HOR_FRONT,
  parameter int HOR_SYNC_PULSE    = VGA_HOR_SYNC,
  parameter int HOR_BACK_PORCH    = VGA_HOR_BACK,
  parameter int VER_ACTIVE_PIXELS = VGA_VER_ACTIVE,
  parameter int VER_FRONT_PORCH   = VGA_VER_FRONT,
  parameter int VER_SYNC_PULSE    = VGA_VER_SYNC,
  parameter int VER_BACK_PORCH    = VGA_VER_BACK,
  parameter bit SYNC_ACTIVE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_scanout_if.master     fb,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic [3:0]        vga_red,
  output logic [3:0]        vga_green,
  output logic [3:0]        vga_blue
);
  localparam int PIXELS_COUNT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;
  localparam int ADDR_WIDTH   = $clog2(PIXELS_COUNT);

  stage_t                stage0;
  stage_t                stage1;
  logic                  frame_start0;
  logic                  vblank0;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  swap_q;
  logic [3:0]            colour;

  vga_scanout_timing #(
    .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
    .HOR_FRONT_PORCH   (HOR_FRONT_PORCH),
    .HOR_SYNC_PULSE    (HOR_SYNC_PULSE),
    .HOR_BACK_PORCH    (HOR_BACK_PORCH),
    .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
    .VER_FRONT_PORCH   (VER_FRONT_PORCH),
    .VER_SYNC_PULSE    (VER_SYNC_PULSE),
    .VER_BACK_PORCH    (VER_BACK_PORCH)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .stage0      (stage0),
    .frame_start (frame_start0),
    .vblank      (vblank0)
  );

  // Wrap on the final pixel so the address never leaves the buffer, even in the last h-blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
    end else if (stage0.active) begin
      addr <= (addr == ADDR_WIDTH'(PIXELS_COUNT - 1)) ? '0 : addr + ADDR_WIDTH'(1);
    end else if (vblank0) begin
      addr <= '0;
    end
  end

  // Stage 1 lines up with the registered RAM output; stage 2 drives the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1    <= '0;
      colour    <= '0;
      vga_hsync <= ~SYNC_ACTIVE_LEVEL;
      vga_vsync <= ~SYNC_ACTIVE_LEVEL;
      swap_q    <= 1'b0;
    end else begin
      stage1    <= stage0;
      colour    <= {4{fb.read_data & stage1.active}};
      vga_hsync <= stage1.hsync ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
      vga_vsync <= stage1.vsync ? SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
      swap_q    <= frame_start0;
    end
  end

  assign fb.read_addr = addr;
  assign fb.swap      = swap_q;
  assign vga_red      = colour;
  assign vga_green    = colour;
  assign vga_blue     = colour;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - randomized self-checking bench for vga_scanout on a scaled-down raster
module tb_vga_scanout;
  localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int F = HT * VT;
  localparam int PIX = HA * VA;
  localparam int AW = $clog2(PIX);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vga_hsync, vga_vsync;
  logic [3:0] vga_red, vga_green, vga_blue;
  bit mem [PIX];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  vga_scanout_if #(.ADDR_WIDTH(AW)) fb ();

  vga_scanout #(
    .HOR_ACTIVE_PIXELS(HA), .HOR_FRONT_PORCH(HFP), .HOR_SYNC_PULSE(HS), .HOR_BACK_PORCH(HBP),
    .VER_ACTIVE_PIXELS(VA), .VER_FRONT_PORCH(VFP), .VER_SYNC_PULSE(VS), .VER_BACK_PORCH(VBP),
    .SYNC_ACTIVE_LEVEL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .fb(fb),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue)
  );

  // Registered-output frame buffer model.
  always @(posedge clk) fb.read_data <= (int'(fb.read_addr) < PIX) ? mem[fb.read_addr] : 1'b0;

  // Reference model: k = cycles since reset release, cycle 0 shows raster position (0,0).
  function automatic int exp_addr(input int k);
    int p, h, v, a;
    p = k % F; h = p % HT; v = p / HT;
    if (v >= VA) return 0;
    a = v * HA + ((h < HA) ? h : HA);
    return (a >= PIX) ? 0 : a;
  endfunction

  function automatic logic exp_hsync(input int k);
    int h;
    if (k < 2) return 1'b1;
    h = ((k - 2) % F) % HT;
    return (h >= HA + HFP && h < HA + HFP + HS) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic exp_vsync(input int k);
    int v;
    if (k < 2) return 1'b1;
    v = ((k - 2) % F) / HT;
    return (v >= VA + VFP && v < VA + VFP + VS) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [3:0] exp_rgb(input int k);
    int p, h, v;
    if (k < 2) return 4'h0;
    p = (k - 2) % F; h = p % HT; v = p / HT;
    if (h < HA && v < VA) return {4{mem[v * HA + h]}};
    return 4'h0;
  endfunction

  function automatic logic exp_swap(input int k);
    return (k >= 1) && (((k - 1) % F) == VA * HT);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < PIX; i++) mem[i] = 1'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fill_mem();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({vga_hsync, vga_vsync, fb.swap} !== 3'b110 || {vga_red, vga_green, vga_blue} !== 12'h0
          || fb.read_addr !== '0) begin
        bad++;
        $display("FAIL reset cyc=%0d got hs/vs/swap=%b rgb=%h addr=%0d exp 110/000/0", i,
                 {vga_hsync, vga_vsync, fb.swap}, {vga_red, vga_green, vga_blue}, fb.read_addr);
      end
    end
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_line_timing();
    int first_fall = -1;
    int low_cnt = 0;
    for (int i = 0; i < 3 * HT; i++) begin
      @(negedge clk);
      cyc++;
      if (vga_hsync === 1'b0 && first_fall < 0) first_fall = cyc;
      if (vga_hsync === 1'b0 && cyc < HT + 2) low_cnt++;
      total++;
      if (vga_hsync !== exp_hsync(cyc)) begin
        bad++;
        $display("FAIL hsync cyc=%0d got=%b exp=%b", cyc, vga_hsync, exp_hsync(cyc));
      end
      total++;
      if (vga_red !== exp_rgb(cyc) || vga_green !== exp_rgb(cyc) || vga_blue !== exp_rgb(cyc)) begin
        bad++;
        $display("FAIL line_rgb cyc=%0d got=%h%h%h exp=%h", cyc, vga_red, vga_green, vga_blue, exp_rgb(cyc));
      end
      total++;
      if (int'(fb.read_addr) !== exp_addr(cyc)) begin
        bad++;
        $display("FAIL line_addr cyc=%0d got=%0d exp=%0d", cyc, fb.read_addr, exp_addr(cyc));
      end
    end
    total++;
    if (first_fall !== HA + HFP + 2) begin
      bad++;
      $display("FAIL hsync_first_fall got=%0d exp=%0d", first_fall, HA + HFP + 2);
    end
    total++;
    if (low_cnt !== HS) begin
      bad++;
      $display("FAIL hsync_width got=%0d exp=%0d", low_cnt, HS);
    end
  endtask

  task automatic test_frame(input int n_cycles, input string tag);
    int swaps = 0;
    int first_swap = -1;
    int vs_low = 0;
    int start = cyc;
    for (int i = 0; i < n_cycles; i++) begin
      @(negedge clk);
      cyc++;
      if (fb.swap === 1'b1) begin
        swaps++;
        if (first_swap < 0) first_swap = cyc;
      end
      if (vga_vsync === 1'b0 && cyc < F + 2) vs_low++;
      total++;
      if ({vga_hsync, vga_vsync, fb.swap} !== {exp_hsync(cyc), exp_vsync(cyc), exp_swap(cyc)}) begin
        bad++;
        $display("FAIL %s_sync cyc=%0d got hs/vs/swap=%b exp=%b", tag, cyc,
                 {vga_hsync, vga_vsync, fb.swap}, {exp_hsync(cyc), exp_vsync(cyc), exp_swap(cyc)});
      end
      total++;
      if (vga_red !== exp_rgb(cyc) || vga_green !== exp_rgb(cyc) || vga_blue !== exp_rgb(cyc)) begin
        bad++;
        $display("FAIL %s_rgb cyc=%0d got=%h%h%h exp=%h", tag, cyc, vga_red, vga_green, vga_blue, exp_rgb(cyc));
      end
      total++;
      if (int'(fb.read_addr) !== exp_addr(cyc)) begin
        bad++;
        $display("FAIL %s_addr cyc=%0d got=%0d exp=%0d", tag, cyc, fb.read_addr, exp_addr(cyc));
      end
    end
    total++;
    if (start < VA * HT + 1 && first_swap !== VA * HT + 1) begin
      bad++;
      $display("FAIL %s_first_swap got=%0d exp=%0d", tag, first_swap, VA * HT + 1);
    end
    total++;
    if (swaps !== (cyc - 1 + F - VA * HT) / F - (start - 1 + F - VA * HT) / F) begin
      bad++;
      $display("FAIL %s_swap_count got=%0d exp=%0d", tag, swaps,
               (cyc - 1 + F - VA * HT) / F - (start - 1 + F - VA * HT) / F);
    end
    total++;
    if (start < 2 && cyc >= F + 2 && vs_low !== VS * HT) begin
      bad++;
      $display("FAIL %s_vsync_width got=%0d exp=%0d", tag, vs_low, VS * HT);
    end
  endtask

  task automatic test_async_reset();
    int tv, th, guard;
    tv = $urandom_range(VA - 1, 1);
    th = $urandom_range(HA - 1, 0);
    guard = 0;
    while ((cyc % F) != tv * HT + th && guard < 2 * F) begin
      @(negedge clk);
      cyc++;
      guard++;
    end
    total++;
    if (guard >= 2 * F) begin
      bad++;
      $display("FAIL async_seek got=%0d exp=%0d", cyc % F, tv * HT + th);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({vga_hsync, vga_vsync, fb.swap} !== 3'b110 || {vga_red, vga_green, vga_blue} !== 12'h0
        || fb.read_addr !== '0) begin
      bad++;
      $display("FAIL async_reset_immediate got hs/vs/swap=%b rgb=%h addr=%0d exp 110/000/0",
               {vga_hsync, vga_vsync, fb.swap}, {vga_red, vga_green, vga_blue}, fb.read_addr);
    end
    fill_mem();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    test_frame(F + 40, "post_reset");
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame(2 * F, "frame");
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
